execute_md: RTL

- Parametrised next-generation execute stage for the RV32 pipeline.
- Keeps the existing behaviour: operand forwarding, ALU source muxing, ALU and ALU_Control datapath, and branch/jump address generation.
- Generalises forwarding to NUM_FWD bypass sources.
- Adds an iterative RV32M multiply/divide unit. While the unit is busy, the block stalls the pipeline through o_stall.
- Sits between the decode/ID-EX register and the EX-MEM register. The hazard unit consumes o_stall.

---
 rtl/execute_md_pkg.sv | 77 +++++++
 rtl/execute_md_md_iter.sv | 156 +++++++++++++++
 rtl/execute_md.sv | 108 ++++++++++
 3 files changed

// File: rtl/execute_md_pkg.sv
// Shared definitions for the execute_md stage: forward-select encoding, ALU op classes,
// RV32M funct3 codes, M-unit FSM states and the ALU_Control decode.
package execute_md_pkg;

    localparam int NO_FWD = 0;

    localparam logic [3:0] ALU_OP_MEM    = 4'd0;
    localparam logic [3:0] ALU_OP_R      = 4'd1;
    localparam logic [3:0] ALU_OP_I      = 4'd2;
    localparam logic [3:0] ALU_OP_BRANCH = 4'd3;
    localparam logic [3:0] ALU_OP_LUI    = 4'd4;
    localparam logic [3:0] ALU_OP_AUIPC  = 4'd5;
    localparam logic [3:0] ALU_OP_JAL    = 4'd6;
    localparam logic [3:0] ALU_OP_I_JUMP = 4'd7;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2,
        MD_FAST = 2'd3
    } md_state_e;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10,
        ALU_LINK  = 4'd11
    } alu_ctrl_e;

    // SUB only exists for register-register ops; SRA/SRAI share the funct7 alternate bit.
    function automatic alu_ctrl_e alu_control(input logic [3:0] alu_op,
                                              input logic [2:0] f3,
                                              input logic [6:0] f7);
        alu_ctrl_e ctrl;
        logic      alt;
        alt  = (f7 == 7'h20);
        ctrl = ALU_ADD;
        case (alu_op)
            ALU_OP_R, ALU_OP_I: begin
                case (f3)
                    3'b000:  ctrl = ((alu_op == ALU_OP_R) && alt) ? ALU_SUB : ALU_ADD;
                    3'b001:  ctrl = ALU_SLL;
                    3'b010:  ctrl = ALU_SLT;
                    3'b011:  ctrl = ALU_SLTU;
                    3'b100:  ctrl = ALU_XOR;
                    3'b101:  ctrl = alt ? ALU_SRA : ALU_SRL;
                    3'b110:  ctrl = ALU_OR;
                    3'b111:  ctrl = ALU_AND;
                    default: ctrl = ALU_ADD;
                endcase
            end
            ALU_OP_BRANCH:           ctrl = ALU_SUB;
            ALU_OP_LUI:              ctrl = ALU_PASSB;
            ALU_OP_JAL, ALU_OP_I_JUMP: ctrl = ALU_LINK;
            default:                 ctrl = ALU_ADD;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/execute_md_md_iter.sv
// md_iter: iterative RV32M unit. Shift-add multiply and restoring divide on magnitudes,
// one bit per cycle, with signs restored when the last step is folded into the result.
module execute_md_md_iter
    import execute_md_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    output logic            done_o,
    output logic            stall_o,
    output logic            busy_o,
    output logic [XLEN-1:0] result_o
);
    localparam int              CW    = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST  = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_V = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e           state_q, state_d;
    logic [CW-1:0]       count_q, count_d;
    logic [2*XLEN-1:0]   acc_q, acc_d, step_s, prod_s;
    logic [XLEN-1:0]     opnd_q, opnd_d, res_q, res_d;
    logic [2:0]          f3_q, f3_d;
    logic                neg_q, neg_d, rneg_q, rneg_d;
    logic                is_div_s, a_neg_s, b_neg_s, fast_s, div_ge_s;
    logic [XLEN-1:0]     a_mag_s, b_mag_s, fast_res_s, fin_s, quo_s, rem_s, div_rem_s;
    logic [XLEN:0]       mul_sum_s, div_sh_s;

    // FSM state register
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= MD_IDLE;
        else         state_q <= state_d;
    end

    // FSM next state; flush wins from any state
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = MD_IDLE;
        end else begin
            case (state_q)
                MD_IDLE: state_d = start_i ? (fast_s ? MD_FAST : MD_BUSY) : MD_IDLE;
                MD_BUSY: state_d = (count_q == LAST) ? MD_DONE : MD_BUSY;
                MD_FAST: state_d = MD_DONE;
                MD_DONE: state_d = MD_IDLE;
                default: state_d = MD_IDLE;
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        busy_o   = (state_q != MD_IDLE);
        done_o   = (state_q == MD_DONE);
        stall_o  = rstn_i & ~flush_i & (((state_q == MD_IDLE) & start_i) |
                                        (state_q == MD_BUSY) | (state_q == MD_FAST));
        result_o = res_q;
    end

    // Operand conditioning at accept, including the two architecturally-defined shortcuts
    always_comb begin
        is_div_s = funct3_i[2];
        a_neg_s  = op_a_i[XLEN-1] & (is_div_s ? ~funct3_i[0] : (funct3_i != F3_MULHU));
        b_neg_s  = op_b_i[XLEN-1] & (is_div_s ? ~funct3_i[0] : ~funct3_i[1]);
        a_mag_s  = a_neg_s ? -op_a_i : op_a_i;
        b_mag_s  = b_neg_s ? -op_b_i : op_b_i;
        fast_s   = is_div_s & ((op_b_i == {XLEN{1'b0}}) |
                   (~funct3_i[0] & (op_a_i == MIN_V) & (&op_b_i)));
        if (op_b_i == {XLEN{1'b0}}) fast_res_s = funct3_i[1] ? op_a_i : {XLEN{1'b1}};
        else                        fast_res_s = funct3_i[1] ? {XLEN{1'b0}} : MIN_V;
    end

    // One iteration step and sign-corrected result of the step
    always_comb begin
        mul_sum_s = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                    (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
        div_sh_s  = acc_q[2*XLEN-1:XLEN-1];
        div_ge_s  = (div_sh_s >= {1'b0, opnd_q});
        div_rem_s = div_ge_s ? XLEN'(div_sh_s - {1'b0, opnd_q}) : div_sh_s[XLEN-1:0];
        step_s    = f3_q[2] ? {div_rem_s, acc_q[XLEN-2:0], div_ge_s}
                            : {mul_sum_s, acc_q[XLEN-1:1]};
        prod_s    = neg_q  ? -step_s : step_s;
        quo_s     = neg_q  ? -step_s[XLEN-1:0] : step_s[XLEN-1:0];
        rem_s     = rneg_q ? -step_s[2*XLEN-1:XLEN] : step_s[2*XLEN-1:XLEN];
        case (f3_q)
            F3_MUL:                       fin_s = prod_s[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fin_s = prod_s[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              fin_s = quo_s;
            default:                      fin_s = rem_s;
        endcase
    end

    // Datapath next state
    always_comb begin
        count_d = count_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        f3_d    = f3_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        res_d   = res_q;
        if (flush_i) begin
            count_d = {CW{1'b0}};
            acc_d   = {(2*XLEN){1'b0}};
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (start_i) begin
                        f3_d    = funct3_i;
                        neg_d   = a_neg_s ^ b_neg_s;
                        rneg_d  = a_neg_s;
                        count_d = {CW{1'b0}};
                        acc_d   = {{XLEN{1'b0}}, (is_div_s ? a_mag_s : b_mag_s)};
                        opnd_d  = is_div_s ? b_mag_s : a_mag_s;
                        res_d   = fast_s ? fast_res_s : res_q;
                    end else begin
                        count_d = count_q;
                    end
                end
                MD_BUSY: begin
                    acc_d   = step_s;
                    count_d = count_q + CW'(1);
                    res_d   = (count_q == LAST) ? fin_s : res_q;
                end
                default: count_d = count_q;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            count_q <= {CW{1'b0}};
            acc_q   <= {(2*XLEN){1'b0}};
            opnd_q  <= {XLEN{1'b0}};
            res_q   <= {XLEN{1'b0}};
            f3_q    <= 3'd0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            res_q   <= res_d;
            f3_q    <= f3_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
        end
    end

endmodule

// File: rtl/execute_md.sv
// RV32 execute stage: NUM_FWD-source forwarding, ALU source muxing, ALU, branch/jump target
// generation and an optional iterative M unit that stalls the pipeline while it works.
module execute_md
    import execute_md_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUM_FWD = 2,
    parameter int FWD_W   = $clog2(NUM_FWD + 1),
    parameter int EN_M    = 1
) (
    input  logic                    i_clk,
    input  logic                    i_rstn,
    input  logic                    i_valid,
    input  logic                    i_flush,
    input  logic                    i_isMulDiv,
    input  logic [6:0]              i_funct7,
    input  logic [2:0]              i_funct3,
    input  logic [3:0]              i_aluOp,
    input  logic [FWD_W-1:0]        i_fwdRs1,
    input  logic [FWD_W-1:0]        i_fwdRs2,
    input  logic                    i_aluSrcA,
    input  logic                    i_aluSrcB,
    input  logic [XLEN-1:0]         i_EXEC_rs1,
    input  logic [XLEN-1:0]         i_EXEC_rs2,
    input  logic [NUM_FWD*XLEN-1:0] i_fwdData,
    input  logic [XLEN-1:0]         i_PC,
    input  logic [XLEN-1:0]         i_IMM,
    output logic [XLEN-1:0]         o_aluOut,
    output logic [XLEN-1:0]         o_addrGenOut,
    output logic [XLEN-1:0]         o_rs2FwdOut,
    output logic                    o_stall,
    output logic                    o_mdBusy
);
    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] rs1f_s, rs2f_s, alu_a_s, alu_b_s, alu_res_s, md_res_s;
    logic [SHW-1:0]  shamt_s;
    logic            md_start_s, md_done_s, md_stall_s, md_busy_s;
    alu_ctrl_e       alu_ctrl_s;

    // Forwarding: selects outside 1..NUM_FWD fall back to the register-file value
    always_comb begin
        rs1f_s = i_EXEC_rs1;
        rs2f_s = i_EXEC_rs2;
        for (int k = 1; k <= NUM_FWD; k++) begin
            rs1f_s = (i_fwdRs1 == FWD_W'(k)) ? i_fwdData[(k-1)*XLEN +: XLEN] : rs1f_s;
            rs2f_s = (i_fwdRs2 == FWD_W'(k)) ? i_fwdData[(k-1)*XLEN +: XLEN] : rs2f_s;
        end
    end

    // ALU source muxing and ALU
    always_comb begin
        alu_a_s    = i_aluSrcA ? i_PC  : rs1f_s;
        alu_b_s    = i_aluSrcB ? i_IMM : rs2f_s;
        alu_ctrl_s = alu_control(i_aluOp, i_funct3, i_funct7);
        shamt_s    = alu_b_s[SHW-1:0];
        case (alu_ctrl_s)
            ALU_ADD:   alu_res_s = alu_a_s + alu_b_s;
            ALU_SUB:   alu_res_s = alu_a_s - alu_b_s;
            ALU_SLL:   alu_res_s = alu_a_s << shamt_s;
            ALU_SLT:   alu_res_s = {{(XLEN-1){1'b0}}, ($signed(alu_a_s) < $signed(alu_b_s))};
            ALU_SLTU:  alu_res_s = {{(XLEN-1){1'b0}}, (alu_a_s < alu_b_s)};
            ALU_XOR:   alu_res_s = alu_a_s ^ alu_b_s;
            ALU_SRL:   alu_res_s = alu_a_s >> shamt_s;
            ALU_SRA:   alu_res_s = $unsigned($signed(alu_a_s) >>> shamt_s);
            ALU_OR:    alu_res_s = alu_a_s | alu_b_s;
            ALU_AND:   alu_res_s = alu_a_s & alu_b_s;
            ALU_PASSB: alu_res_s = alu_b_s;
            ALU_LINK:  alu_res_s = alu_a_s + XLEN'(32'd4);
            default:   alu_res_s = alu_a_s + alu_b_s;
        endcase
    end

    // Target generation and result steering
    always_comb begin
        o_addrGenOut = (i_aluOp == ALU_OP_I_JUMP) ? ((rs1f_s + i_IMM) & ~XLEN'(32'd1))
                                                  : (i_PC + i_IMM);
        o_rs2FwdOut  = rs2f_s;
        md_start_s   = i_valid & i_isMulDiv & ~i_flush;
        o_aluOut     = md_done_s ? md_res_s : alu_res_s;
        o_stall      = md_stall_s;
        o_mdBusy     = md_busy_s;
    end

    generate
        if (EN_M != 0) begin : g_md
            execute_md_md_iter #(.XLEN(XLEN)) u_md_iter (
                .clk_i    (i_clk),
                .rstn_i   (i_rstn),
                .start_i  (md_start_s),
                .flush_i  (i_flush),
                .funct3_i (i_funct3),
                .op_a_i   (rs1f_s),
                .op_b_i   (rs2f_s),
                .done_o   (md_done_s),
                .stall_o  (md_stall_s),
                .busy_o   (md_busy_s),
                .result_o (md_res_s)
            );
        end else begin : g_no_md
            assign md_done_s  = 1'b0;
            assign md_stall_s = 1'b0;
            assign md_busy_s  = 1'b0;
            assign md_res_s   = {XLEN{1'b0}};
        end
    endgenerate

endmodule
